seq_divider: RTL and testbench

Multi-cycle iterative divider for the Atom core, implementing RV32M DIV/DIVU/REM/REMU. It is the division counterpart to the single-cycle ALU datapath and sits beside the ALU in the execute stage. It uses a valid/ready request channel and a valid/ready response channel, so the pipeline stalls while a division is in flight. It is a radix-2 restoring divider operating on operand magnitudes, with a sign fix-up at the end.

---
 rtl/seq_divider.sv | 173 +++++++++++++++++
 tb/tb_seq_divider.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready request and response channels.
// Optional macro DIV_EARLY_OUT_EN: requests with |b| > |a| finish in one cycle without iterating.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] quo_r, quo_s;
  logic [WIDTH-1:0] div_r, div_s;
  logic [1:0]       op_r, op_s;
  logic             qsign_r, qsign_s;
  logic             rsign_r, rsign_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             req_ready_r, resp_valid_r, busy_r;

  logic             is_signed_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic             is_ovf_s;
  logic [WIDTH:0]   shifted_s, diff_s;
  logic [WIDTH-1:0] rem_step_s, quo_step_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    neg = {WIDTH{1'b0}} - x;
  endfunction

  // Operand magnitudes, overflow detection and the restoring step
  always_comb begin
    is_signed_s = ~op_i[0];
    a_mag_s     = (is_signed_s && a_i[WIDTH-1]) ? neg(a_i) : a_i;
    b_mag_s     = (is_signed_s && b_i[WIDTH-1]) ? neg(b_i) : b_i;
    is_ovf_s    = is_signed_s && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == {WIDTH{1'b1}});
    shifted_s   = {rem_r, quo_r[WIDTH-1]};
    diff_s      = shifted_s - {1'b0, div_r};
    if (!diff_s[WIDTH]) begin
      rem_step_s = diff_s[WIDTH-1:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_step_s = shifted_s[WIDTH-1:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
    end
    quo_fix_s = qsign_r ? neg(quo_step_s) : quo_step_s;
    rem_fix_s = rsign_r ? neg(rem_step_s) : rem_step_s;
  end

  // Next-state and datapath update
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    rem_s    = rem_r;
    quo_s    = quo_r;
    div_s    = div_r;
    op_s     = op_r;
    qsign_s  = qsign_r;
    rsign_s  = rsign_r;
    result_s = result_r;
    case (state_r)
      IDLE: begin
        if (flush_i) begin
          state_s = IDLE;
        end else if (req_valid_i && req_ready_r) begin
          op_s    = op_i;
          div_s   = b_mag_s;
          rem_s   = {WIDTH{1'b0}};
          quo_s   = a_mag_s;
          qsign_s = is_signed_s && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rsign_s = is_signed_s && a_i[WIDTH-1];
          cnt_s   = {CW{1'b0}};
          if (b_i == {WIDTH{1'b0}}) begin
            state_s  = DONE;
            result_s = op_i[1] ? a_i : {WIDTH{1'b1}};
          end else if (is_ovf_s) begin
            state_s  = DONE;
            result_s = op_i[1] ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
`ifdef DIV_EARLY_OUT_EN
          end else if (b_mag_s > a_mag_s) begin
            state_s  = DONE;
            result_s = op_i[1] ? a_i : {WIDTH{1'b0}};
`endif
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_s = IDLE;
        end else begin
          rem_s = rem_step_s;
          quo_s = quo_step_s;
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_s  = DONE;
            result_s = op_r[1] ? rem_fix_s : quo_fix_s;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
      end
      DONE: begin
        if (flush_i || resp_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      rem_r        <= {WIDTH{1'b0}};
      quo_r        <= {WIDTH{1'b0}};
      div_r        <= {WIDTH{1'b0}};
      op_r         <= 2'b00;
      qsign_r      <= 1'b0;
      rsign_r      <= 1'b0;
      result_r     <= {WIDTH{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      rem_r        <= rem_s;
      quo_r        <= quo_s;
      div_r        <= div_s;
      op_r         <= op_s;
      qsign_r      <= qsign_s;
      rsign_r      <= rsign_s;
      result_r     <= result_s;
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == DONE);
      busy_r       <= (state_s != IDLE);
    end
  end

  assign req_ready_o  = req_ready_r;
  assign resp_valid_o = resp_valid_r;
  assign result_o     = result_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: arithmetic, latency, special cases, backpressure, flush and reset.
module tb_seq_divider;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .a_i(a), .b_i(b),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .result_o(result), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request, count cycles until resp_valid, then check latency and value and drain.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int cyc;
    op = o; a = x; b = y; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_val"}, result, exp);
    step();
  endtask

  initial begin
    int seen;
    logic [31:0] held;

    step();
    step();
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'h0);

    run("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("div_7_m2",  OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run("rem_7_m2",  OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run("rem_m7_m2", OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
    run("div_min_2", OP_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 33);
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run("remu_ff_16", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
    run("divu_ff_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    run("div_5_0",   OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_5_0",   OP_REM,  32'd5, 32'd0, 32'd5, 1);
    run("divu_0_0",  OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_m5_0",  OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    run("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'd0, EO_LAT);
    run("remu_3_10", OP_REMU, 32'd3, 32'd10, 32'd3, EO_LAT);

    // Backpressure: response must hold for 10 cycles while resp_ready is low.
    resp_ready = 1'b0;
    op = OP_DIVU; a = 32'd100; b = 32'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    seen = 0;
    while (!resp_valid && seen < 100) begin
      step();
      seen++;
    end
    check("bp_rise", 32'(resp_valid), 32'd1);
    held = result;
    check("bp_first_val", held, 32'd14);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_result", result, held);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    check("bp_release_ready", 32'(req_ready), 32'd1);
    check("bp_release_valid", 32'(resp_valid), 32'd0);

    // Flush in IDLE drops a simultaneous request.
    op = OP_DIVU; a = 32'd9; b = 32'd3; req_valid = 1'b1; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 32'(busy), 32'd0);
    check("idle_flush_ready", 32'(req_ready), 32'd1);

    // Flush at T+10 kills the operation.
    op = OP_DIVU; a = 32'd100; b = 32'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("kill_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("kill_ready", 32'(req_ready), 32'd1);
    check("kill_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      step();
    end
    check("kill_no_valid", 32'(seen), 32'd0);
    run("after_flush_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Reset mid-operation clears all outputs.
    op = OP_DIVU; a = 32'd100; b = 32'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", 32'(resp_valid), 32'd0);
    check("mrst_result", result, 32'h0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      step();
    end
    check("mrst_no_valid", 32'(seen), 32'd0);
    run("after_rst_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
